multiword_add_sequencer: RTL and testbench



---
 rtl/multiword_add_sequencer.sv | 91 +++++++++
 tb/tb_multiword_add_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/multiword_add_sequencer.sv
// Streams a WORDS x N-bit add/sub through an external N-bit adder, one slice per cycle, LSB first.
// Latency WORDS cycles accept-to-out_valid; result held in DONE until out_ready, no request taken meanwhile.
module multiword_add_sequencer #(
  parameter int N     = 32,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WORDS-1:0]   op_a,
  input  logic [N*WORDS-1:0]   op_b,
  input  logic                 sub,
  input  logic                 cin,
  output logic [N-1:0]         add_a,
  output logic [N-1:0]         add_b,
  output logic                 add_cin,
  input  logic [N-1:0]         add_s,
  input  logic                 add_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WORDS-1:0]   sum,
  output logic                 cout,
  output logic                 overflow
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                    state;
  logic [WORDS-1:0][N-1:0]   a_q;
  logic [WORDS-1:0][N-1:0]   b_q;
  logic [WORDS-1:0][N-1:0]   sum_q;
  logic [IW-1:0]             idx;
  logic                      carry;
  logic                      ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      idx   <= '0;
      carry <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= op_a;
            // Subtraction is A + ~B + 1; the +1 rides in on the first slice carry.
            b_q   <= sub ? ~op_b : op_b;
            carry <= sub | cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_q[idx] <= add_s;
          carry      <= add_cout;
          if (idx == LAST) begin
            ovf_q <= (a_q[WORDS-1][N-1] == b_q[WORDS-1][N-1]) &&
                     (add_s[N-1] != a_q[WORDS-1][N-1]);
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_q;
  // The carry register keeps the final carry-out until the next accept reloads it.
  assign cout      = carry;
  assign overflow  = ovf_q;

  assign add_a   = (state == RUN) ? a_q[idx] : '0;
  assign add_b   = (state == RUN) ? b_q[idx] : '0;
  assign add_cin = (state == RUN) ? carry : 1'b0;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Bench for multiword_add_sequencer: vector table plus scoreboard, backpressure and async-reset sequences.
module tb_multiword_add_sequencer;

  localparam int N     = 32;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   op_a = '0;
  logic [W-1:0]   op_b = '0;
  logic           sub = 1'b0;
  logic           cin = 1'b0;
  logic [N-1:0]   add_a;
  logic [N-1:0]   add_b;
  logic           add_cin;
  logic [N-1:0]   add_s;
  logic           add_cout;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   sum;
  logic           cout;
  logic           overflow;

  always #5 clk = ~clk;

  // External combinational slice adder.
  always_comb {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};

  multiword_add_sequencer #(.N(N), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub), .cin(cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  res_t sbq[$];
  vec_t tbl[10];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event t=%0t", name, $time);
  endtask

  // Full-width reference: one wide addition, no slicing.
  function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic s, input logic c);
    vec_t         v;
    logic [W-1:0] be;
    logic [W:0]   t;
    be = s ? ~b : b;
    t  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (s ? 1'b1 : c)};
    v  = '{a, b, s, c, t[W-1:0], t[W], (a[W-1] == be[W-1]) && (t[W-1] != a[W-1])};
    return v;
  endfunction

  // Carry expected into slice k: carry out of the low k*N bits of the wide sum.
  function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] be,
                                      input logic c0, input int k);
    logic [W:0] mask, t;
    mask = ((W+1)'(1) << (k * N)) - 1'b1;
    t    = ({1'b0, a} & mask) + ({1'b0, be} & mask) + {{W{1'b0}}, c0};
    return t[k * N];
  endfunction

  function automatic logic [W-1:0] rnd_w();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_op(input vec_t v, input int hold);
    logic [W-1:0] be;
    logic         c0;
    int           n;
    res_t         r;
    be = v.sub ? ~v.b : v.b;
    c0 = v.sub ? 1'b1 : v.cin;
    in_valid = 1'b1; op_a = v.a; op_b = v.b; sub = v.sub; cin = v.cin;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) begin note_fail("accept"); in_valid = 1'b0; return; end
    @(posedge clk);
    sbq.push_back('{v.sum, v.cout, v.ovf});
    #1;
    in_valid = 1'b0; op_a = rnd_w(); op_b = rnd_w(); sub = ~sub; cin = ~cin;
    for (int k = 0; k < WORDS; k++) begin
      @(negedge clk);
      chk("run_out_valid", out_valid, 0);
      chk("run_in_ready", in_ready, 0);
      chk("add_a_slice", add_a, v.a[k*N +: N]);
      chk("add_b_slice", add_b, be[k*N +: N]);
      chk("add_cin_slice", add_cin, carry_into(v.a, be, c0, k));
    end
    @(negedge clk);
    chk("latency_out_valid", out_valid, 1);
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    if (!out_valid) begin note_fail("done_wait"); return; end
    if (sbq.size() == 0) begin note_fail("scoreboard_empty"); return; end
    r = sbq.pop_front();
    chk("sum", sum, r.sum);
    chk("cout", cout, r.cout);
    chk("overflow", overflow, r.ovf);
    chk("done_add_cin", add_cin, 0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; op_a = rnd_w(); op_b = rnd_w();
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_sum", sum, r.sum);
      chk("hold_cout", cout, r.cout);
      chk("hold_ovf", overflow, r.ovf);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 0);
    chk("release_sum_held", sum, r.sum);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{{W{1'b1}}, 128'd1, 1'b0, 1'b0, 128'd0, 1'b1, 1'b0};
    tbl[1] = '{128'd0, 128'd1, 1'b1, 1'b1, {W{1'b1}}, 1'b0, 1'b0};
    tbl[2] = '{128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0, 1'b0,
               128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b1};
    tbl[3] = '{128'd25, 128'd75, 1'b0, 1'b1, 128'd101, 1'b0, 1'b0};
    tbl[4] = '{128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'd1, 1'b1, 1'b0,
               128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    tbl[5] = '{128'h0000_0000_FFFF_FFFF_0000_0000_0000_0000,
               128'h0000_0000_0000_0001_0000_0000_0000_0000, 1'b0, 1'b0,
               128'h0000_0001_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0};
    for (int i = 6; i < 10; i++)
      tbl[i] = mk(rnd_w(), rnd_w(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_cin", add_cin, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      run_op(tbl[i], (i == 2) ? 5 : 0);

    // Async reset while slice 2 is on the adder.
    in_valid = 1'b1; op_a = tbl[3].a; op_b = tbl[3].b; sub = tbl[3].sub; cin = tbl[3].cin;
    @(posedge clk);
    sbq.push_back('{tbl[3].sum, tbl[3].cout, tbl[3].ovf});
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_add_a", add_a, 0);
    chk("pre_rst_in_ready", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_sum", sum, 0);
    chk("midrst_add_cin", add_cin, 0);
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_op(tbl[3], 0);
    run_op(tbl[0], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
